// File: rtl/dxball_pkg.sv
// Shared DX-Ball playfield geometry and brick-manager types.
// Purpose : one place for the screen/brick geometry used by the brick
//           manager, the collision logic and the renderer.
// Contents: geometry constants, brick address type, manager FSM states.
package dxball_pkg;

  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;
  localparam int BRICK_W    = 16;
  localparam int BRICK_H    = 10;
  localparam int COLS       = 10;
  localparam int ROWS       = 2;
  localparam int NUM_BRICKS = COLS * ROWS;
  localparam int POINTS     = 10;

  typedef logic [7:0] brick_addr_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    DIV,
    ERASE
  } brick_mgr_state_t;

endpackage

// File: rtl/brick_addr_divider.sv
// Iterative brick address -> (col,row) divider.
// Purpose : splits a linear brick address into row (quotient) and column
//           (remainder) by repeated subtraction of DIVISOR, one step per
//           cycle. Reusable by the renderer.
// Ports   : clock, resetn    - clock, async active-low reset
//           start, dividend  - load a new address (restarts any division)
//           done             - high in the cycle the result is final
//           quotient         - row of the address
//           remainder        - column of the address
module brick_addr_divider
  import dxball_pkg::*;
#(
  parameter int DIVISOR = dxball_pkg::COLS
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  brick_addr_t dividend,
  output logic        done,
  output brick_addr_t quotient,
  output brick_addr_t remainder
);

  localparam brick_addr_t DIV_C = brick_addr_t'(DIVISOR);

  logic busy;

  // done is combinational so the consumer can register its result in the
  // same cycle the remainder drops below the divisor.
  assign done = busy && (remainder < DIV_C);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      busy      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (start) begin
      busy      <= 1'b1;
      quotient  <= '0;
      remainder <= dividend;
    end else if (busy) begin
      if (remainder >= DIV_C) begin
        remainder <= remainder - DIV_C;
        quotient  <= quotient + 8'd1;
      end else begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/brick_map_manager.sv
// DX-Ball brick map manager.
// Purpose : owns the alive bitmap of all bricks, confirms/rejects hit
//           reports, keeps score and bricks-left, asks the drawer to erase
//           destroyed bricks and refills the map on level load.
// Ports   : clock, resetn                 - clock, async active-low reset
//           level_load                    - refill request (single cycle)
//           hit_valid/hit_ready/hit_addr  - hit report handshake
//           hit_accepted, hit_miss        - 1-cycle verdict pulses
//           erase_req/erase_ack           - erase handshake to the drawer
//           erase_x, erase_y              - top-left of rectangle to erase
//           rd_addr, rd_alive             - registered read port
//           score, bricks_left            - game counters
//           level_clear                   - sticky, set when no bricks left
module brick_map_manager
  import dxball_pkg::*;
#(
  parameter int COLS    = dxball_pkg::COLS,
  parameter int ROWS    = dxball_pkg::ROWS,
  parameter int BRICK_W = dxball_pkg::BRICK_W,
  parameter int BRICK_H = dxball_pkg::BRICK_H,
  parameter int POINTS  = dxball_pkg::POINTS
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        level_load,
  input  logic        hit_valid,
  output logic        hit_ready,
  input  logic [7:0]  hit_addr,
  output logic        hit_accepted,
  output logic        hit_miss,
  output logic        erase_req,
  input  logic        erase_ack,
  output logic [7:0]  erase_x,
  output logic [6:0]  erase_y,
  input  logic [7:0]  rd_addr,
  output logic        rd_alive,
  output logic [15:0] score,
  output logic [7:0]  bricks_left,
  output logic        level_clear
);

  localparam int          NB   = COLS * ROWS;
  localparam brick_addr_t NB_A = brick_addr_t'(NB);
  localparam logic [15:0] PTS  = 16'(POINTS);

  brick_mgr_state_t state, state_next;

  logic [NB-1:0] bitmap;
  brick_addr_t   addr;
  logic          load_pending;

  logic          do_load;
  logic          div_start;
  logic          div_done;
  brick_addr_t   div_row;
  brick_addr_t   div_col;

  // Bitmap lookups by shifting the selected bit down to position 0; the
  // explicit range check keeps out-of-range addresses reading as dead.
  logic [NB-1:0] addr_shift;
  logic [NB-1:0] rd_shift;
  logic          addr_alive;
  logic          rd_bit;

  assign addr_shift = bitmap >> addr;
  assign rd_shift   = bitmap >> rd_addr;
  assign addr_alive = (addr < NB_A) && addr_shift[0];
  assign rd_bit     = (rd_addr < NB_A) && rd_shift[0];

  brick_addr_divider #(
    .DIVISOR (COLS)
  ) u_div (
    .clock     (clock),
    .resetn    (resetn),
    .start     (div_start),
    .dividend  (addr),
    .done      (div_done),
    .quotient  (div_row),
    .remainder (div_col)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    hit_ready  = 1'b0;
    do_load    = 1'b0;
    div_start  = 1'b0;
    unique case (state)
      IDLE: begin
        // A pending or fresh load wins over any hit presented this cycle.
        if (load_pending || level_load) begin
          do_load    = 1'b1;
          state_next = LOAD;
        end else begin
          hit_ready = 1'b1;
          if (hit_valid) state_next = CHECK;
        end
      end
      LOAD:  state_next = IDLE;
      CHECK: begin
        if (addr_alive) begin
          div_start  = 1'b1;
          state_next = DIV;
        end else begin
          state_next = IDLE;
        end
      end
      DIV:   if (div_done)  state_next = ERASE;
      ERASE: if (erase_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bitmap       <= '1;
      bricks_left  <= NB_A;
      score        <= '0;
      level_clear  <= 1'b0;
      load_pending <= 1'b0;
      addr         <= '0;
      hit_accepted <= 1'b0;
      hit_miss     <= 1'b0;
      erase_req    <= 1'b0;
      erase_x      <= '0;
      erase_y      <= '0;
      rd_alive     <= 1'b0;
    end else begin
      hit_accepted <= 1'b0;
      hit_miss     <= 1'b0;
      // Read returns the bitmap before any write in this same cycle.
      rd_alive     <= rd_bit;

      if (do_load)                          load_pending <= 1'b0;
      else if (level_load && state != IDLE) load_pending <= 1'b1;

      unique case (state)
        IDLE: begin
          // The refill is committed on the way into LOAD, so the refilled
          // counters are already visible during the LOAD cycle.
          if (do_load) begin
            bitmap      <= '1;
            bricks_left <= NB_A;
            level_clear <= 1'b0;
          end else if (hit_valid) begin
            addr <= hit_addr;
          end
        end
        CHECK: begin
          if (addr_alive) begin
            bitmap       <= bitmap & ~({{(NB-1){1'b0}}, 1'b1} << addr);
            bricks_left  <= bricks_left - 8'd1;
            score        <= (score > 16'hFFFF - PTS) ? 16'hFFFF : score + PTS;
            hit_accepted <= 1'b1;
            if (bricks_left == 8'd1) level_clear <= 1'b1;
          end else begin
            hit_miss <= 1'b1;
          end
        end
        DIV: begin
          if (div_done) begin
            erase_x   <= 8'(div_col * BRICK_W);
            erase_y   <= 7'(div_row * BRICK_H);
            erase_req <= 1'b1;
          end
        end
        ERASE: if (erase_ack) erase_req <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_brick_map_manager.sv
module tb_brick_map_manager;

  logic        clock;
  logic        resetn;
  logic        level_load;
  logic        hit_valid;
  logic        hit_ready;
  logic [7:0]  hit_addr;
  logic        hit_accepted;
  logic        hit_miss;
  logic        erase_req;
  logic        erase_ack;
  logic [7:0]  erase_x;
  logic [6:0]  erase_y;
  logic [7:0]  rd_addr;
  logic        rd_alive;
  logic [15:0] score;
  logic [7:0]  bricks_left;
  logic        level_clear;

  int total = 0;
  int bad   = 0;

  // Reference model of the playfield (10 x 2 bricks, 16 x 10 px, 10 points).
  bit model_alive [20];
  int m_score;
  int m_left;
  bit m_clear;

  typedef struct {
    bit accepted;
    int x;
    int y;
    int lat;
  } exp_t;
  exp_t sb[$];

  brick_map_manager dut (
    .clock        (clock),
    .resetn       (resetn),
    .level_load   (level_load),
    .hit_valid    (hit_valid),
    .hit_ready    (hit_ready),
    .hit_addr     (hit_addr),
    .hit_accepted (hit_accepted),
    .hit_miss     (hit_miss),
    .erase_req    (erase_req),
    .erase_ack    (erase_ack),
    .erase_x      (erase_x),
    .erase_y      (erase_y),
    .rd_addr      (rd_addr),
    .rd_alive     (rd_alive),
    .score        (score),
    .bricks_left  (bricks_left),
    .level_clear  (level_clear)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < 20; i++) model_alive[i] = 1'b1;
    m_score = 0;
    m_left  = 20;
    m_clear = 1'b0;
  endtask

  task automatic model_refill();
    for (int i = 0; i < 20; i++) model_alive[i] = 1'b1;
    m_left  = 20;
    m_clear = 1'b0;
  endtask

  task automatic check_counters(input string tag);
    total++;
    if (score !== m_score[15:0] || bricks_left !== m_left[7:0] || level_clear !== m_clear) begin
      bad++;
      $display("FAIL %s counters: score=%0d left=%0d clear=%b required score=%0d left=%0d clear=%b",
               tag, score, bricks_left, level_clear, m_score, m_left, m_clear);
    end
  endtask

  task automatic check_reads(input string tag);
    int addrs [21];
    bit exp;
    for (int i = 0; i < 20; i++) addrs[i] = i;
    addrs[20] = 25;
    for (int i = 0; i < 21; i++) begin
      @(negedge clock);
      rd_addr = addrs[i][7:0];
      @(negedge clock);
      exp = (addrs[i] < 20) ? model_alive[addrs[i]] : 1'b0;
      total++;
      if (rd_alive !== exp) begin
        bad++;
        $display("FAIL %s rd_alive[%0d]: got %b required %b", tag, addrs[i], rd_alive, exp);
      end
    end
    $display("reads %s: 21 addresses checked", tag);
  endtask

  // One hit transaction: drive, push expectation, then pop and compare at
  // the verdict cycle and follow the erase handshake if a brick was hit.
  task automatic do_hit(input int a, input int ack_wait, input bit load_in_erase, input int next_addr);
    exp_t e;
    exp_t got;
    int   lat;
    @(negedge clock);
    hit_valid = 1'b1;
    hit_addr  = a[7:0];
    lat = 0;
    while (!hit_ready && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    total++;
    if (!hit_ready) begin
      bad++;
      $display("FAIL hit_ready_wait addr=%0d: hit_ready=%b required 1", a, hit_ready);
      hit_valid = 1'b0;
      return;
    end
    e.accepted = (a < 20) && model_alive[a];
    e.x   = (a % 10) * 16;
    e.y   = (a / 10) * 10;
    e.lat = 3 + a / 10;
    if (e.accepted) begin
      model_alive[a] = 1'b0;
      m_left--;
      m_score = (m_score + 10 > 65535) ? 65535 : m_score + 10;
      if (m_left == 0) m_clear = 1'b1;
    end
    sb.push_back(e);

    @(negedge clock);            // T+1
    hit_valid = 1'b0;
    @(negedge clock);            // T+2
    got = sb.pop_front();
    total++;
    if (hit_accepted !== got.accepted || hit_miss !== !got.accepted) begin
      bad++;
      $display("FAIL verdict addr=%0d: accepted=%b miss=%b required accepted=%b miss=%b",
               a, hit_accepted, hit_miss, got.accepted, !got.accepted);
    end
    check_counters($sformatf("hit%0d", a));

    if (got.accepted) begin
      lat = 2;
      while (!erase_req && lat < 12) begin
        @(negedge clock);
        lat++;
      end
      total++;
      if (lat !== got.lat) begin
        bad++;
        $display("FAIL erase_latency addr=%0d: got T+%0d required T+%0d", a, lat, got.lat);
      end
      total++;
      if (erase_x !== got.x[7:0] || erase_y !== got.y[6:0]) begin
        bad++;
        $display("FAIL erase_coords addr=%0d: got x=%0d y=%0d required x=%0d y=%0d",
                 a, erase_x, erase_y, got.x, got.y);
      end
      for (int i = 0; i < ack_wait; i++) begin
        if (load_in_erase && i == 0) level_load = 1'b1;
        @(negedge clock);
        level_load = 1'b0;
        if (load_in_erase && i == 0) begin
          hit_valid = 1'b1;
          hit_addr  = next_addr[7:0];
        end
        total++;
        if (erase_req !== 1'b1 || erase_x !== got.x[7:0] || erase_y !== got.y[6:0]) begin
          bad++;
          $display("FAIL erase_hold addr=%0d cycle %0d: req=%b x=%0d y=%0d required req=1 x=%0d y=%0d",
                   a, i, erase_req, erase_x, erase_y, got.x, got.y);
        end
      end
      erase_ack = 1'b1;
      @(negedge clock);
      erase_ack = 1'b0;
      total++;
      if (erase_req !== 1'b0) begin
        bad++;
        $display("FAIL erase_drop addr=%0d: erase_req=%b required 0", a, erase_req);
      end
      if (load_in_erase) begin
        total++;
        if (hit_ready !== 1'b0) begin
          bad++;
          $display("FAIL pending_load_ready: hit_ready=%b required 0", hit_ready);
        end
        @(negedge clock);
        model_refill();
        total++;
        if (hit_ready !== 1'b0 || bricks_left !== 8'd20 || level_clear !== 1'b0) begin
          bad++;
          $display("FAIL pending_load_run: ready=%b left=%0d clear=%b required ready=0 left=20 clear=0",
                   hit_ready, bricks_left, level_clear);
        end
      end else begin
        total++;
        if (hit_ready !== 1'b1) begin
          bad++;
          $display("FAIL ready_after_ack addr=%0d: hit_ready=%b required 1", a, hit_ready);
        end
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clock);
        total++;
        if (erase_req !== 1'b0) begin
          bad++;
          $display("FAIL no_erase addr=%0d: erase_req=%b required 0", a, erase_req);
        end
      end
    end
    $display("hit addr=%0d accepted=%b score=%0d left=%0d", a, got.accepted, score, bricks_left);
  endtask

  task automatic test_reset();
    resetn     = 1'b0;
    level_load = 1'b0;
    hit_valid  = 1'b0;
    hit_addr   = '0;
    erase_ack  = 1'b0;
    rd_addr    = '0;
    model_reset();
    repeat (3) @(negedge clock);
    total++;
    if (hit_ready !== 1'b1 || hit_accepted !== 1'b0 || hit_miss !== 1'b0 || erase_req !== 1'b0 ||
        rd_alive !== 1'b0 || erase_x !== 8'd0 || erase_y !== 7'd0) begin
      bad++;
      $display("FAIL reset_outputs: ready=%b acc=%b miss=%b req=%b rd=%b x=%0d y=%0d required 1,0,0,0,0,0,0",
               hit_ready, hit_accepted, hit_miss, erase_req, rd_alive, erase_x, erase_y);
    end
    check_counters("reset");
    resetn = 1'b1;
    check_reads("after_reset");
  endtask

  task automatic test_hit_row0();
    do_hit(3, 5, 1'b0, 0);
    check_reads("after_hit3");
  endtask

  task automatic test_hit_row1_repeat();
    do_hit(13, 2, 1'b0, 0);
    do_hit(13, 0, 1'b0, 0);
  endtask

  task automatic test_out_of_range();
    do_hit(200, 0, 1'b0, 0);
  endtask

  task automatic test_clear_all();
    for (int i = 0; i < 20; i++) begin
      if (model_alive[i]) do_hit(i, 0, 1'b0, 0);
    end
    total++;
    if (level_clear !== 1'b1 || bricks_left !== 8'd0 || score !== 16'd200) begin
      bad++;
      $display("FAIL clear_all: clear=%b left=%0d score=%0d required clear=1 left=0 score=200",
               level_clear, bricks_left, score);
    end
  endtask

  task automatic test_level_load();
    @(negedge clock);
    level_load = 1'b1;
    @(negedge clock);
    level_load = 1'b0;
    model_refill();
    check_counters("level_load");
    $display("level_load: left=%0d clear=%b score=%0d", bricks_left, level_clear, score);
  endtask

  task automatic test_pending_load();
    do_hit(5, 2, 1'b1, 7);
    do_hit(7, 0, 1'b0, 0);
    do_hit(5, 0, 1'b0, 0);
  endtask

  task automatic test_reset_mid_erase();
    int lat;
    @(negedge clock);
    hit_valid = 1'b1;
    hit_addr  = 8'd14;
    lat = 0;
    while (!hit_ready && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    @(negedge clock);
    hit_valid = 1'b0;
    lat = 0;
    while (!erase_req && lat < 12) begin
      @(negedge clock);
      lat++;
    end
    total++;
    if (erase_req !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_erase_setup: erase_req=%b required 1", erase_req);
    end
    @(negedge clock);
    resetn = 1'b0;
    #1;
    model_reset();
    total++;
    if (erase_req !== 1'b0 || hit_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_erase: erase_req=%b hit_ready=%b required 0,1", erase_req, hit_ready);
    end
    check_counters("reset_mid_erase");
    @(negedge clock);
    resetn = 1'b1;
    check_reads("after_mid_reset");
  endtask

  initial begin
    test_reset();
    test_hit_row0();
    test_hit_row1_repeat();
    test_out_of_range();
    test_clear_all();
    test_level_load();
    test_pending_load();
    test_reset_mid_erase();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/brick_map_manager.md
Name: brick_map_manager

Overview:
Owns the alive/dead state of every brick in the DX-Ball playfield. It is the responder to the brick collision logic: it accepts a hit report on a brick address and confirms or rejects it. On a confirmed hit it clears the brick, updates score and bricks-remaining, and asks the VGA drawer to erase the brick rectangle. It also serves a registered read port for the collision and render paths, and refills the map on level load.

Parameters:
COLS, 10, bricks per row (160 px / 16 px)
ROWS, 2, brick rows
BRICK_W, 16, brick width in pixels
BRICK_H, 10, brick height in pixels
POINTS, 10, score added per destroyed brick
Constraint: COLS*ROWS <= 255

Ports:
clock  in  1  system clock (all state on rising edge)
resetn  in  1  asynchronous active-low reset
level_load  in  1  single-cycle request to refill all bricks
hit_valid  in  1  collision logic presents a hit
hit_ready  out  1  manager can accept a hit
hit_addr  in  8  brick address, row*COLS+col
hit_accepted  out  1  1-cycle pulse: brick was alive and is now destroyed
hit_miss  out  1  1-cycle pulse: brick already dead or address out of range
erase_req  out  1  request to drawer to erase a rectangle
erase_ack  in  1  drawer finished erase
erase_x  out  8  top-left x of rectangle to erase
erase_y  out  7  top-left y of rectangle to erase
rd_addr  in  8  read address
rd_alive  out  1  alive bit of rd_addr, 1-cycle latency
score  out  16  accumulated score
bricks_left  out  8  live brick count
level_clear  out  1  high when bricks_left==0, sticky until level load

Behaviour:
- Reset (resetn=0, async): state IDLE; bitmap all ones; bricks_left=COLS*ROWS; score=0; hit_ready=1; hit_accepted, hit_miss, erase_req, rd_alive, level_clear=0; erase_x, erase_y=0; load_pending=0.
- FSM states: IDLE, LOAD, CHECK, DIV, ERASE.
- IDLE: hit_ready=1, except in a cycle where load_pending or level_load is set. Then it goes to LOAD and the hit is not accepted. Otherwise hit_valid&&hit_ready at cycle T latches hit_addr and goes to CHECK.
- LOAD (1 cycle): bitmap all ones, bricks_left=COLS*ROWS, level_clear=0, load_pending=0; score unchanged; goes to IDLE.
- level_load in any non-IDLE state sets load_pending. LOAD then runs on the next entry to IDLE. An in-flight hit/erase always completes first.
- CHECK (cycle T+1):
  - If addr>=COLS*ROWS or the bit is 0: hit_miss=1 during T+2, return to IDLE.
  - Otherwise: clear the bit, bricks_left-=1, score+=POINTS (saturating at 16'hFFFF), hit_accepted=1 during T+2, go to DIV.
  - level_clear registers high in the same cycle bricks_left becomes 0.
- DIV: iterative divide. rem=addr, row=0 on entry. Each cycle, if rem>=COLS then rem-=COLS and row+=1. Otherwise erase_x=rem*BRICK_W, erase_y=row*BRICK_H, erase_req=1, go to ERASE.
  - erase_req first visible at T+3+row. Example: row 0 at T+3, row 1 at T+4.
- ERASE: erase_req, erase_x and erase_y are held stable until erase_ack is sampled high. Next cycle erase_req=0 and state is IDLE. erase_ack outside ERASE is ignored.
- Minimum hit-to-hit spacing: erase_ack cycle + 1.
- Read port: rd_alive registered every cycle from the bitmap value before any same-cycle write. rd_addr>=COLS*ROWS returns 0.
- Arithmetic:
  - erase_x fits 8 bits for COLS*BRICK_W<=256.
  - erase_y fits 7 bits for ROWS*BRICK_H<=128.
  - bricks_left never wraps (decrement only on alive bit).

Decomposition:
- Shared package dxball_pkg:
  - constants SCREEN_W=160, SCREEN_H=120, BRICK_W, BRICK_H, COLS, ROWS, NUM_BRICKS.
  - typedef brick_addr_t (8 bit).
  - enum typedef brick_mgr_state_t {IDLE, LOAD, CHECK, DIV, ERASE}.
  - The collision logic uses the same geometry constants.
- One sub-module: brick_addr_divider. It does iterative address to (col,row) with start/done, and is reusable by the renderer.

Test Plan:
- Reset then rd_addr=0..19 -> rd_alive=1 for all, rd_addr=25 -> 0; bricks_left=20, score=0.
- Hit addr 3 at T -> hit_accepted at T+2; erase_req at T+3 with erase_x=48, erase_y=0. Hold erase_ack low 5 cycles -> request and coordinates stable. Ack -> hit_ready=1 next cycle; score=10, bricks_left=19, rd_alive(3)=0.
- Hit addr 13 -> erase_req at T+4, erase_x=48, erase_y=10. Repeat hit addr 13 -> hit_miss at T+2, no erase_req, score unchanged.
- Hit addr 200 -> hit_miss, no state change.
- Destroy all 20 -> level_clear=1 as bricks_left reaches 0, score=200. Then level_load -> next cycle bricks_left=20, level_clear=0, score=200.
- level_load asserted during ERASE with hit_valid held high -> erase completes, LOAD runs before the pending hit is accepted (hit_ready low in that IDLE cycle). resetn asserted mid-ERASE -> erase_req=0 immediately, bitmap full.
